// File: rtl/program_counter.sv
// Fetch-stage program counter: increments each cycle, or loads a jump/branch
// target when the instruction is a jump or a conditional branch whose flag test passes.
module program_counter #(
  parameter int I_ADDR_W = 12,
  parameter int DATA_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [I_ADDR_W-1:0] imar,
  input  logic [I_ADDR_W-1:0] address_immediate,
  input  logic                jump_branch_select,
  input  logic                immediate_select,
  input  logic                unconditional_branch,
  input  logic [DATA_W-1:0]   status_register,
  input  logic [2:0]          branch_condition,
  output logic [I_ADDR_W-1:0] pc
);

  typedef enum logic [2:0] {
    COND_ZERO             = 3'd0,
    COND_NOT_ZERO         = 3'd1,
    COND_POSITIVE         = 3'd2,
    COND_NEGATIVE         = 3'd3,
    COND_CARRY_SET        = 3'd4,
    COND_CARRY_CLEARED    = 3'd5,
    COND_OVERFLOW_SET     = 3'd6,
    COND_OVERFLOW_CLEARED = 3'd7
  } branch_condition_e;

  localparam int ZERO_FLAG     = 0;
  localparam int POSITIVE_FLAG = 1;
  localparam int CARRY_FLAG    = 2;
  localparam int OVERFLOW_FLAG = 3;

  logic [I_ADDR_W-1:0] r_pc;
  logic                w_condition_met;
  logic                w_take;
  logic [I_ADDR_W-1:0] w_target;
  logic [I_ADDR_W-1:0] w_next_pc;
  logic                w_zero;
  logic                w_positive;
  logic                w_carry;
  logic                w_overflow;

  assign w_zero     = status_register[ZERO_FLAG];
  assign w_positive = status_register[POSITIVE_FLAG];
  assign w_carry    = status_register[CARRY_FLAG];
  assign w_overflow = status_register[OVERFLOW_FLAG];

  // Only the low four flag bits matter; upper status bits are don't-care.
  generate
    if (DATA_W > 4) begin : g_unused_status
      logic w_unused_status;
      assign w_unused_status = ^status_register[DATA_W-1:4];
    end
  endgenerate

  always_comb begin
    w_condition_met = 1'b0;
    case (branch_condition_e'(branch_condition))
      COND_ZERO:             w_condition_met = w_zero;
      COND_NOT_ZERO:         w_condition_met = ~w_zero;
      COND_POSITIVE:         w_condition_met = w_positive;
      COND_NEGATIVE:         w_condition_met = ~w_positive;
      COND_CARRY_SET:        w_condition_met = w_carry;
      COND_CARRY_CLEARED:    w_condition_met = ~w_carry;
      COND_OVERFLOW_SET:     w_condition_met = w_overflow;
      COND_OVERFLOW_CLEARED: w_condition_met = ~w_overflow;
      default:               w_condition_met = 1'b0;
    endcase
  end

  assign w_take    = jump_branch_select & (unconditional_branch | w_condition_met);
  assign w_target  = immediate_select ? address_immediate : imar;
  assign w_next_pc = w_take ? w_target : r_pc + I_ADDR_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= '0;
    end else begin
      r_pc <= w_next_pc;
    end
  end

  assign pc = r_pc;

endmodule

// File: tb/tb_program_counter.sv
// Directed bench for program_counter: reset, increment, jumps, condition sweep,
// target select, wrap-around and asynchronous mid-run reset.
module tb_program_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] imar;
  logic [11:0] address_immediate;
  logic        jump_branch_select;
  logic        immediate_select;
  logic        unconditional_branch;
  logic [7:0]  status_register;
  logic [2:0]  branch_condition;
  logic [11:0] pc;

  int checks = 0;
  int errors = 0;

  program_counter #(.I_ADDR_W(12), .DATA_W(8)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .imar                 (imar),
    .address_immediate    (address_immediate),
    .jump_branch_select   (jump_branch_select),
    .immediate_select     (immediate_select),
    .unconditional_branch (unconditional_branch),
    .status_register      (status_register),
    .branch_condition     (branch_condition),
    .pc                   (pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: pc=0x%03h expected 0x%03h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic jump_to(input logic [11:0] tgt);
    jump_branch_select   = 1'b1;
    unconditional_branch = 1'b1;
    immediate_select     = 1'b1;
    address_immediate    = tgt;
    step();
    jump_branch_select   = 1'b0;
    unconditional_branch = 1'b0;
  endtask

  // One taken cycle (loads tgt) then one violating cycle (tgt+1).
  task automatic run_cond(input logic [2:0] c, input logic [7:0] sr_take,
                          input logic [7:0] sr_viol, input logic [11:0] tgt,
                          input logic [11:0] exp_viol);
    jump_branch_select   = 1'b1;
    unconditional_branch = 1'b0;
    immediate_select     = 1'b1;
    branch_condition     = c;
    status_register      = sr_take;
    address_immediate    = tgt;
    step();
    check($sformatf("cond%0d_taken", c), pc, tgt);
    status_register   = sr_viol;
    address_immediate = 12'hE00;
    step();
    check($sformatf("cond%0d_not_taken", c), pc, exp_viol);
  endtask

  initial begin
    rst                  = 1'b1;
    imar                 = 12'h000;
    address_immediate    = 12'h000;
    jump_branch_select   = 1'b0;
    immediate_select     = 1'b0;
    unconditional_branch = 1'b0;
    status_register      = 8'h00;
    branch_condition     = 3'd0;

    step();
    check("reset_cycle0", pc, 12'h000);
    step();
    check("reset_cycle1", pc, 12'h000);
    rst = 1'b0;

    for (int i = 1; i <= 10; i++) begin
      step();
      check($sformatf("incr_%0d", i), pc, 12'(i));
    end

    jump_to(12'h100);
    check("uncond_imm", pc, 12'h100);
    jump_branch_select   = 1'b1;
    unconditional_branch = 1'b1;
    immediate_select     = 1'b0;
    imar                 = 12'h200;
    address_immediate    = 12'h0F0;
    step();
    check("uncond_imar", pc, 12'h200);
    jump_to(12'h123);
    check("b2b_123", pc, 12'h123);
    jump_to(12'h456);
    check("b2b_456", pc, 12'h456);
    jump_to(12'h789);
    check("b2b_789", pc, 12'h789);

    run_cond(3'd0, 8'h01, 8'hFE, 12'h300, 12'h301);
    run_cond(3'd1, 8'hF0, 8'h01, 12'h310, 12'h311);
    run_cond(3'd2, 8'h02, 8'hFD, 12'h320, 12'h321);
    run_cond(3'd3, 8'hFD, 8'h02, 12'h330, 12'h331);
    run_cond(3'd4, 8'h04, 8'hFB, 12'h340, 12'h341);
    run_cond(3'd5, 8'h0B, 8'h04, 12'h350, 12'h351);
    run_cond(3'd6, 8'h08, 8'hF7, 12'h360, 12'h361);
    run_cond(3'd7, 8'h07, 8'h08, 12'h370, 12'h371);

    jump_branch_select   = 1'b1;
    unconditional_branch = 1'b0;
    immediate_select     = 1'b0;
    branch_condition     = 3'd0;
    status_register      = 8'h01;
    imar                 = 12'h5A5;
    address_immediate    = 12'h111;
    step();
    check("cond_imar_select", pc, 12'h5A5);

    jump_branch_select   = 1'b0;
    unconditional_branch = 1'b1;
    immediate_select     = 1'b1;
    status_register      = 8'hFF;
    step();
    check("no_jump_ignores_uncond", pc, 12'h5A6);
    unconditional_branch = 1'b0;

    jump_to(12'hFFF);
    check("wrap_load", pc, 12'hFFF);
    step();
    check("wrap_zero", pc, 12'h000);
    step();
    check("wrap_one", pc, 12'h001);

    jump_to(12'h456);
    check("pre_reset", pc, 12'h456);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", pc, 12'h000);
    jump_branch_select   = 1'b1;
    unconditional_branch = 1'b1;
    address_immediate    = 12'h789;
    step();
    check("reset_hold_branch0", pc, 12'h000);
    step();
    check("reset_hold_branch1", pc, 12'h000);
    rst                  = 1'b0;
    jump_branch_select   = 1'b0;
    unconditional_branch = 1'b0;
    step();
    check("post_reset_incr", pc, 12'h001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
